// File: rtl/pc_jump_unit.sv
// ---------------------------------------------------------------------------
// pc_jump_unit
//   Program counter with a run-time writable jump-target table. A jump is
//   either relative (pc + signed table entry, modulo 2**D) or absolute
//   (pc = table entry). Supplies the instruction ROM address and is steered
//   by the control decoder.
//
// Parameters
//   D        PC / table-entry width (offsets are two's complement)
//   A        table address width
//   DEPTH    implemented table entries (DEPTH <= 2**A)
//   START_PC PC value loaded on reset and on start
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      launch program from START_PC (honoured in IDLE or HALTED)
//   halt_req   stop execution, PC frozen
//   stall      hold PC this cycle
//   jump_en    take the jump selected by jump_addr
//   jump_abs   1 = absolute target, 0 = relative offset
//   jump_addr  table entry used by this jump
//   lut_we     table write enable
//   lut_waddr  table write address
//   lut_wdata  table write data
//   pc         current program counter (registered)
//   target     combinational table read of jump_addr
//   running    1 while in RUN (registered)
//   done       1 while in HALTED (registered)
//   wrap       1-cycle flag: last PC update wrapped modulo 2**D (registered)
// ---------------------------------------------------------------------------
module pc_jump_unit #(
    parameter int unsigned D        = 12,
    parameter int unsigned A        = 6,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned START_PC = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         halt_req,
    input  logic         stall,
    input  logic         jump_en,
    input  logic         jump_abs,
    input  logic [A-1:0] jump_addr,
    input  logic         lut_we,
    input  logic [A-1:0] lut_waddr,
    input  logic [D-1:0] lut_wdata,
    output logic [D-1:0] pc,
    output logic [D-1:0] target,
    output logic         running,
    output logic         done,
    output logic         wrap
);

    // Full 2**A address space is declared so every address indexes cleanly;
    // only entries below DEPTH are ever written or read back.
    localparam int unsigned ENTRIES = 1 << A;
    // Relative sum carries two extra bits so the true signed result is exact.
    localparam int unsigned SW      = D + 2;
    localparam int unsigned DP1     = D + 1;
    localparam logic [D-1:0] START  = D'(START_PC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic          wrap_q, wrap_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic [D-1:0]  lut_q [ENTRIES];

    logic [SW-1:0] rel_sum;
    logic [D:0]    inc_sum;
    logic          waddr_ok;

    // Table read; addresses at or beyond DEPTH read as zero.
    always_comb begin
        target = '0;
        if (32'(jump_addr) < DEPTH) begin
            target = lut_q[jump_addr];
        end
    end

    assign waddr_ok = (32'(lut_waddr) < DEPTH);

    // Unbounded pc + signed entry; any nonzero top bit means the result left
    // [0, 2**D-1] (carry-out or borrow past zero).
    assign rel_sum = {2'b00, pc_q} + {{2{target[D-1]}}, target};
    assign inc_sum = {1'b0, pc_q} + DP1'(1);

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrap_d    = 1'b0;
        running_d = running_q;
        done_d    = done_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d   = S_RUN;
                    pc_d      = START;
                    running_d = 1'b1;
                    done_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d   = S_HALTED;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (jump_en) begin
                    if (jump_abs) begin
                        pc_d = target;
                    end else begin
                        pc_d   = rel_sum[D-1:0];
                        wrap_d = |rel_sum[SW-1:D];
                    end
                end else begin
                    pc_d   = inc_sum[D-1:0];
                    wrap_d = inc_sum[D];
                end
            end
            default: begin
                state_d   = S_IDLE;
                running_d = 1'b0;
                done_d    = 1'b0;
            end
        endcase
    end

    // State, outputs and table storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= START;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                lut_q[A'(i)] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
            done_q    <= done_d;
            // Write lands on this edge; a same-edge jump already used the old value.
            if (lut_we && waddr_ok) begin
                lut_q[lut_waddr] <= lut_wdata;
            end
        end
    end

    assign pc      = pc_q;
    assign wrap    = wrap_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pc_jump_unit.sv
module tb_pc_jump_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic        jump_abs = 1'b0;
    logic [5:0]  jump_addr = 6'd0;
    logic        lut_we = 1'b0;
    logic [5:0]  lut_waddr = 6'd0;
    logic [11:0] lut_wdata = 12'd0;

    logic [11:0] pc_a, target_a, pc_b, target_b;
    logic        running_a, done_a, wrap_a;
    logic        running_b, done_b, wrap_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [11:0] pc_a;
        logic        wrap_a;
        logic [11:0] pc_b;
        logic        wrap_b;
        logic        running;
        logic        done;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_jump_unit #(.D(12), .A(6), .DEPTH(64), .START_PC(0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .stall(stall), .jump_en(jump_en), .jump_abs(jump_abs),
        .jump_addr(jump_addr), .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .pc(pc_a), .target(target_a),
        .running(running_a), .done(done_a), .wrap(wrap_a)
    );

    pc_jump_unit #(.D(12), .A(6), .DEPTH(40), .START_PC(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .stall(stall), .jump_en(jump_en), .jump_abs(jump_abs),
        .jump_addr(jump_addr), .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .pc(pc_b), .target(target_b),
        .running(running_b), .done(done_b), .wrap(wrap_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Push expectation, clock one edge, pop and compare at the falling edge.
    task automatic step_ab(input string tag, input logic [11:0] pa, input logic wa,
                           input logic [11:0] pb, input logic wb,
                           input logic r, input logic d);
        exp_t e;
        e.tag = tag; e.pc_a = pa; e.wrap_a = wa; e.pc_b = pb; e.wrap_b = wb;
        e.running = r; e.done = d;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("%s/a", e.tag), {17'd0, pc_a, wrap_a, running_a, done_a},
            {17'd0, e.pc_a, e.wrap_a, e.running, e.done});
        chk($sformatf("%s/b", e.tag), {17'd0, pc_b, wrap_b, running_b, done_b},
            {17'd0, e.pc_b, e.wrap_b, e.running, e.done});
    endtask

    task automatic step(input string tag, input logic [11:0] p, input logic w,
                        input logic r, input logic d);
        step_ab(tag, p, w, p, w, r, d);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [11:0] data);
        lut_we = 1'b1; lut_waddr = addr; lut_wdata = data;
        step("idle_write", 12'h000, 1'b0, 1'b0, 1'b0);
        lut_we = 1'b0;
    endtask

    task automatic jmp(input logic abs, input logic [5:0] addr);
        jump_en = 1'b1; jump_abs = abs; jump_addr = addr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        jump_addr = 6'd2;
        @(negedge clk);
        chk("reset_state", {17'd0, pc_a, wrap_a, running_a, done_a}, 32'd0);
        chk("reset_target", {20'd0, target_a}, 32'd0);
        reset = 1'b0;

        // Preload the table while IDLE.
        wr(6'd2, 12'hFF6);
        wr(6'd0, 12'hFFB);
        wr(6'd5, 12'h123);
        wr(6'd3, 12'h008);
        wr(6'd6, 12'h032);
        wr(6'd7, 12'hFFE);
        wr(6'd9, 12'h025);
        wr(6'd50, 12'h005);
        jump_addr = 6'd2;
        #1;
        chk("target_read_a", {20'd0, target_a}, {20'd0, 12'hFF6});
        chk("target_read_b", {20'd0, target_b}, {20'd0, 12'hFF6});

        // jump_en/stall have no effect in IDLE.
        jmp(1'b1, 6'd5); stall = 1'b1;
        step("idle_ignore", 12'h000, 1'b0, 1'b0, 1'b0);
        jump_en = 1'b0; stall = 1'b0;

        start = 1'b1;
        step("start", 12'h000, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) step("inc", 12'(i), 1'b0, 1'b1, 1'b0);

        jmp(1'b0, 6'd2);
        step("rel_back", 12'd10, 1'b0, 1'b1, 1'b0);

        jmp(1'b1, 6'd5); stall = 1'b1;
        step("stall_over_jump", 12'd10, 1'b0, 1'b1, 1'b0);
        stall = 1'b0; halt_req = 1'b1;
        step("halt_over_jump", 12'd10, 1'b0, 1'b0, 1'b1);
        halt_req = 1'b0;
        step("halted_hold", 12'd10, 1'b0, 1'b0, 1'b1);
        jump_en = 1'b0;

        start = 1'b1;
        step("restart", 12'h000, 1'b0, 1'b1, 1'b0);
        step("start_in_run", 12'h001, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 2; i <= 4; i++) step("inc", 12'(i), 1'b0, 1'b1, 1'b0);

        jmp(1'b0, 6'd0);
        step("wrap_neg", 12'hFFF, 1'b1, 1'b1, 1'b0);
        jump_en = 1'b0;
        step("wrap_inc", 12'h000, 1'b1, 1'b1, 1'b0);
        step("inc_nowrap", 12'h001, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= 7; i++) step("inc", 12'(i), 1'b0, 1'b1, 1'b0);

        jmp(1'b1, 6'd5);
        #1;
        chk("abs_target", {20'd0, target_a}, {20'd0, 12'h123});
        step("abs", 12'h123, 1'b0, 1'b1, 1'b0);
        jmp(1'b1, 6'd6);
        step("abs_50", 12'd50, 1'b0, 1'b1, 1'b0);

        // Same-edge write and jump: jump uses the old entry.
        jmp(1'b0, 6'd3);
        lut_we = 1'b1; lut_waddr = 6'd3; lut_wdata = 12'd59;
        step("collide_old", 12'd58, 1'b0, 1'b1, 1'b0);
        lut_we = 1'b0;
        step("collide_new", 12'd117, 1'b0, 1'b1, 1'b0);

        jmp(1'b1, 6'd7);
        step("abs_fffe", 12'hFFE, 1'b0, 1'b1, 1'b0);
        // Entry 50 exists only in the DEPTH=64 build; DEPTH=40 reads 0 and holds.
        jmp(1'b0, 6'd50);
        step_ab("depth_limit", 12'h003, 1'b1, 12'hFFE, 1'b0, 1'b1, 1'b0);
        jmp(1'b1, 6'd9);
        step("abs_37", 12'd37, 1'b0, 1'b1, 1'b0);
        jump_en = 1'b0; jump_addr = 6'd2;

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        chk("async_reset_a", {17'd0, pc_a, wrap_a, running_a, done_a}, 32'd0);
        chk("async_reset_b", {17'd0, pc_b, wrap_b, running_b, done_b}, 32'd0);
        chk("async_reset_table", {20'd0, target_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("post_reset_idle", 12'h000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
